fifo_bank_seq_ctrl: RTL and testbench

// - Sequences a bank of NUM_FIFO single-clock skew FIFOs that feed the systolic array edge.
// - Per job: clear all pointers, write cfg_len words into every FIFO in parallel (input handshake),

---
 rtl/fifo_ctrl_pkg.sv | 28 ++
 rtl/fifo_bank_seq_ctrl_skew_window_gen.sv | 31 +++
 rtl/fifo_bank_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_fifo_bank_seq_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the skew-FIFO bank sequencer: state encoding, default sizes
// and a helper that derives the minimum counter width from the bank geometry.
package fifo_ctrl_pkg;

  localparam int DEF_NUM_FIFO  = 16;
  localparam int DEF_FIFO_SIZE = 16;
  localparam int DEF_CNT_WIDTH = 6;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR,
    WRITE = ST_WRITE,
    READ  = ST_READ,
    DONE  = ST_DONE
  } state_t;

  // Bits needed to count up to fifo_size + num_fifo - 1 (the longest read sweep).
  function automatic int cnt_width_for(input int fifo_size, input int num_fifo);
    return $clog2(fifo_size + num_fifo);
  endfunction

endpackage

// File: rtl/fifo_bank_seq_ctrl_skew_window_gen.sv
// Diagonal read window: lane i is active while i <= rd_cnt < i + len.
// Purely combinational; en gates the whole window off outside the read phase.
module skew_window_gen
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_FIFO  = DEF_NUM_FIFO,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] rd_cnt,
  input  logic [CNT_WIDTH-1:0] len,
  output logic [NUM_FIFO-1:0]  window
);

  // One extra bit so i + len never wraps.
  localparam int W = CNT_WIDTH + 1;

  logic [W-1:0] cnt_ext;
  logic [W-1:0] len_ext;

  assign cnt_ext = {1'b0, rd_cnt};
  assign len_ext = {1'b0, len};

  always_comb begin
    window = '0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      window[i] = en && (cnt_ext >= W'(i)) && (cnt_ext < (W'(i) + len_ext));
    end
  end

endmodule

// File: rtl/fifo_bank_seq_ctrl.sv
// Job sequencer for a bank of skew FIFOs: clear pointers, parallel write of len words,
// then a diagonally skewed drain where lane i lags lane 0 by i cycles.
module fifo_bank_seq_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_FIFO  = DEF_NUM_FIFO,
  parameter int FIFO_SIZE = DEF_FIFO_SIZE,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUM_FIFO-1:0]  wr_clr,
  output logic [NUM_FIFO-1:0]  rd_clr,
  output logic [NUM_FIFO-1:0]  wr_en,
  output logic [NUM_FIFO-1:0]  wr_inc,
  output logic [NUM_FIFO-1:0]  rd_en,
  output logic [NUM_FIFO-1:0]  rd_inc,
  output logic [NUM_FIFO-1:0]  lane_valid,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_WIDTH-1:0] SIZE_C = CNT_WIDTH'(FIFO_SIZE);
  localparam int W = CNT_WIDTH + 1;

  state_t state, state_n;

  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] wr_cnt;
  logic [CNT_WIDTH-1:0] rd_cnt;
  logic [CNT_WIDTH-1:0] len_sat;
  logic                 wr_last;
  logic                 rd_last;
  logic                 read_act;
  logic [NUM_FIFO-1:0]  window;

  assign len_sat = (cfg_len > SIZE_C) ? SIZE_C : cfg_len;
  assign wr_last = (wr_cnt + CNT_WIDTH'(1)) == len_q;
  // Sweep ends when rd_cnt reaches len_q + NUM_FIFO - 2; written as +1 so NUM_FIFO=1 works.
  assign rd_last = ({1'b0, rd_cnt} + W'(1)) == ({1'b0, len_q} + W'(NUM_FIFO - 1));

  skew_window_gen #(
    .NUM_FIFO  (NUM_FIFO),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_window (
    .en     (read_act),
    .rd_cnt (rd_cnt),
    .len    (len_q),
    .window (window)
  );

  assign rd_en  = window;
  assign rd_inc = window;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      lane_valid <= '0;
    end else begin
      state      <= state_n;
      lane_valid <= rd_en;
      if (state == IDLE && start) begin
        len_q <= len_sat;
      end
      if (state == CLEAR) begin
        wr_cnt <= '0;
      end else if (state == WRITE && in_valid) begin
        wr_cnt <= wr_cnt + CNT_WIDTH'(1);
      end
      if (state == WRITE) begin
        rd_cnt <= '0;
      end else if (state == READ) begin
        rd_cnt <= rd_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    wr_clr   = '0;
    rd_clr   = '0;
    wr_en    = '0;
    wr_inc   = '0;
    read_act = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = CLEAR;
      end
      CLEAR: begin
        wr_clr  = '1;
        rd_clr  = '1;
        state_n = (len_q == '0) ? DONE : WRITE;
      end
      WRITE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en  = '1;
          wr_inc = '1;
          if (wr_last) state_n = READ;
        end
      end
      READ: begin
        read_act = 1'b1;
        if (rd_last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_bank_seq_ctrl.sv
// Directed bench for fifo_bank_seq_ctrl with a 4-lane, 16-deep bank: per-cycle vector
// table for the basic/stall/zero-length jobs plus hand sequences for the long corner cases.
module tb_fifo_bank_seq_ctrl;

  localparam int NF = 4;
  localparam int FS = 16;
  localparam int CW = 6;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_len;
  logic          in_valid;
  logic          in_ready;
  logic [NF-1:0] wr_clr, rd_clr, wr_en, wr_inc, rd_en, rd_inc, lane_valid;
  logic          busy;
  logic          done;

  fifo_bank_seq_ctrl #(
    .NUM_FIFO  (NF),
    .FIFO_SIZE (FS),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_len    (cfg_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_clr     (wr_clr),
    .rd_clr     (rd_clr),
    .wr_en      (wr_en),
    .wr_inc     (wr_inc),
    .rd_en      (rd_en),
    .rd_inc     (rd_inc),
    .lane_valid (lane_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [30:0] obs;
  assign obs = {in_ready, wr_clr, rd_clr, wr_en, wr_inc, rd_en, rd_inc, lane_valid, busy, done};

  typedef struct {
    logic          start;
    logic [CW-1:0] len;
    logic          iv;
    logic [30:0]   exp;
  } vec_t;

  vec_t vecs[$];

  int n_chk  = 0;
  int n_fail = 0;

  int beats, reads, dones, clears, nrd;
  logic [NF-1:0] rd_log[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic [CW-1:0] l, input logic iv,
                     input logic ir, input logic [3:0] clr, input logic [3:0] wr,
                     input logic [3:0] rd, input logic [3:0] lv, input logic b, input logic d);
    vec_t v;
    v.start = s;
    v.len   = l;
    v.iv    = iv;
    v.exp   = {ir, clr, clr, wr, wr, rd, rd, lv, b, d};
    vecs.push_back(v);
  endtask

  // Runs one job from IDLE with in_valid held high; optionally re-asserts start during READ.
  task automatic run_job(input logic [CW-1:0] len, input bit poke);
    bit got_done;
    beats = 0; reads = 0; dones = 0; clears = 0; nrd = 0; got_done = 0;
    start = 1'b1; cfg_len = len; in_valid = 1'b1;
    for (int c = 0; c < 200 && !got_done; c++) begin
      #1;
      if (|wr_en) beats++;
      if (|rd_en) begin
        if (nrd < 8) rd_log[nrd] = rd_en;
        nrd++;
        reads++;
      end
      if (|wr_clr) clears++;
      if (done) begin
        dones++;
        got_done = 1;
      end
      @(negedge clk);
      start   = poke && (|rd_en);
      cfg_len = poke ? CW'(5) : len;
    end
    start = 1'b0;
    check("job_done_seen", 32'(got_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0;

    // Basic job, len 3
    add(1, 3, 1,  0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    add(0, 0, 1,  0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 0);
    add(0, 0, 1,  1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0);
    add(0, 0, 1,  1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0);
    add(0, 0, 1,  1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0);
    add(0, 0, 1,  0, 4'h0, 4'h0, 4'h1, 4'h0, 1, 0);
    add(0, 0, 1,  0, 4'h0, 4'h0, 4'h3, 4'h1, 1, 0);
    add(0, 0, 1,  0, 4'h0, 4'h0, 4'h7, 4'h3, 1, 0);
    add(0, 0, 1,  0, 4'h0, 4'h0, 4'hE, 4'h7, 1, 0);
    add(0, 0, 1,  0, 4'h0, 4'h0, 4'hC, 4'hE, 1, 0);
    add(0, 0, 1,  0, 4'h0, 4'h0, 4'h8, 4'hC, 1, 0);
    add(0, 0, 1,  0, 4'h0, 4'h0, 4'h0, 4'h8, 1, 1);
    add(0, 0, 0,  0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    // Write stall, len 2, in_valid 1,0,0,1
    add(1, 2, 1,  0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    add(0, 0, 1,  0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 0);
    add(0, 0, 1,  1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0);
    add(0, 0, 0,  1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0);
    add(0, 0, 0,  1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0);
    add(0, 0, 1,  1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 0);
    add(0, 0, 1,  0, 4'h0, 4'h0, 4'h1, 4'h0, 1, 0);
    add(0, 0, 1,  0, 4'h0, 4'h0, 4'h3, 4'h1, 1, 0);
    add(0, 0, 1,  0, 4'h0, 4'h0, 4'h6, 4'h3, 1, 0);
    add(0, 0, 1,  0, 4'h0, 4'h0, 4'hC, 4'h6, 1, 0);
    add(0, 0, 1,  0, 4'h0, 4'h0, 4'h8, 4'hC, 1, 0);
    add(0, 0, 1,  0, 4'h0, 4'h0, 4'h0, 4'h8, 1, 1);
    add(0, 0, 0,  0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    // Zero-length job
    add(1, 0, 0,  0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    add(0, 0, 0,  0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 0);
    add(0, 0, 0,  0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1);
    add(0, 0, 0,  0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 32'(obs), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      start    = vecs[i].start;
      cfg_len  = vecs[i].len;
      in_valid = vecs[i].iv;
      #1;
      n_chk++;
      if (obs !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL vec[%0d]: got %h, expected %h", i, obs, vecs[i].exp);
      end
      @(negedge clk);
    end

    // Saturation: cfg_len 20 behaves as 16
    run_job(CW'(20), 0);
    check("sat_beats", 32'(beats), 32'd16);
    check("sat_reads", 32'(reads), 32'd19);
    check("sat_dones", 32'(dones), 32'd1);

    // start during READ is ignored
    run_job(CW'(2), 1);
    check("poke_reads", 32'(reads), 32'd5);
    check("poke_clears", 32'(clears), 32'd1);
    #1;
    check("poke_idle_busy", 32'(busy), 32'd0);
    check("poke_idle_done", 32'(done), 32'd0);
    run_job(CW'(1), 0);
    check("after_poke_clears", 32'(clears), 32'd1);
    check("after_poke_reads", 32'(reads), 32'd4);

    // Reset mid-WRITE after one beat
    start = 1'b1; cfg_len = CW'(3); in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_in_write", 32'(in_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_abort_outputs", 32'(obs), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_job(CW'(1), 0);
    check("post_rst_beats", 32'(beats), 32'd1);
    check("post_rst_nrd", 32'(nrd), 32'd4);
    check("post_rst_rd0", 32'(rd_log[0]), 32'h1);
    check("post_rst_rd1", 32'(rd_log[1]), 32'h2);
    check("post_rst_rd2", 32'(rd_log[2]), 32'h4);
    check("post_rst_rd3", 32'(rd_log[3]), 32'h8);
    check("post_rst_dones", 32'(dones), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
